// File: rtl/rtc_bus_sequencer.sv
// Single-byte read/write sequencer for the RTC multiplexed address/data bus.
// Drives the bus mux channels and phase selects plus the chip strobes.
module rtc_bus_sequencer #(
  parameter int unsigned T_SU  = 2,
  parameter int unsigned T_PW  = 4,
  parameter int unsigned T_HD  = 2,
  parameter int unsigned CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       write,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] data_in,
  output logic [7:0] addr_out,
  output logic [7:0] data_out,
  output logic       ch0_mux1,
  output logic       ch1_mux1,
  output logic       bus_oe,
  output logic       cs_n,
  output logic       ad,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, FIN
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               write_q, write_d;
  logic               cs_n_q, cs_n_d;
  logic               ad_q, ad_d;
  logic               wr_n_q, wr_n_d;
  logic               rd_n_q, rd_n_d;
  logic               ch0_q, ch0_d;
  logic               ch1_q, ch1_d;
  logic               oe_q, oe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               phase_end;

  // Counter preload for the state being entered (duration minus one).
  function automatic logic [CNT_W-1:0] load_cnt(input state_e s);
    case (s)
      A_SET, D_SET: load_cnt = CNT_W'(T_SU - 1);
      A_STB, D_STB: load_cnt = CNT_W'(T_PW - 1);
      A_HLD, D_HLD: load_cnt = CNT_W'(T_HD - 1);
      default:      load_cnt = '0;
    endcase
  endfunction

  assign phase_end = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    write_d = write_q;
    rdata_d = rdata_q;
    cs_n_d  = 1'b1;
    ad_d    = 1'b1;
    wr_n_d  = 1'b1;
    rd_n_d  = 1'b1;
    ch0_d   = 1'b1;
    ch1_d   = 1'b0;
    oe_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: if (start) begin
        state_d = A_SET;
        addr_d  = addr;
        data_d  = wdata;
        write_d = write;
      end
      A_SET: if (phase_end) state_d = A_STB;
      A_STB: if (phase_end) state_d = A_HLD;
      A_HLD: if (phase_end) state_d = D_SET;
      D_SET: if (phase_end) state_d = D_STB;
      D_STB: if (phase_end) state_d = D_HLD;
      D_HLD: if (phase_end) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = load_cnt(state_d);
    else if (!phase_end)    cnt_d = cnt_q - CNT_W'(1);

    if (state_q == D_STB && phase_end && !write_q) rdata_d = data_in;

    // Outputs are registered copies of the decode of the state being entered.
    case (state_d)
      A_SET, A_STB, A_HLD: begin
        cs_n_d = 1'b0;
        ad_d   = 1'b0;
        ch0_d  = 1'b0;
        oe_d   = 1'b1;
        busy_d = 1'b1;
        if (state_d == A_STB) wr_n_d = 1'b0;
      end
      D_SET, D_STB, D_HLD: begin
        cs_n_d = 1'b0;
        ch0_d  = 1'b0;
        ch1_d  = 1'b1;
        oe_d   = write_d;
        busy_d = 1'b1;
        if (state_d == D_STB) begin
          if (write_d) wr_n_d = 1'b0;
          else         rd_n_d = 1'b0;
        end
      end
      FIN: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      rdata_q <= 8'h00;
      write_q <= 1'b0;
      cs_n_q  <= 1'b1;
      ad_q    <= 1'b1;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      ch0_q   <= 1'b1;
      ch1_q   <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      cs_n_q  <= cs_n_d;
      ad_q    <= ad_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      ch0_q   <= ch0_d;
      ch1_q   <= ch1_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign addr_out = addr_q;
  assign data_out = data_q;
  assign rdata    = rdata_q;
  assign cs_n     = cs_n_q;
  assign ad       = ad_q;
  assign wr_n     = wr_n_q;
  assign rd_n     = rd_n_q;
  assign ch0_mux1 = ch0_q;
  assign ch1_mux1 = ch1_q;
  assign bus_oe   = oe_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: default timing DUT plus a 1/1/1 timing DUT.
module tb_rtc_bus_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter DUT
  logic       start = 1'b0, write = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00, data_in = 8'h00;
  logic [7:0] addr_out, data_out, rdata;
  logic       ch0_mux1, ch1_mux1, bus_oe, cs_n, ad, wr_n, rd_n, busy, done;

  // Fast DUT
  logic       start1 = 1'b0, write1 = 1'b0;
  logic [7:0] addr1 = 8'h00, wdata1 = 8'h00, data_in1 = 8'h00;
  logic [7:0] addr_out1, data_out1, rdata1;
  logic       ch0_mux1_1, ch1_mux1_1, bus_oe1, cs_n1, ad1, wr_n1, rd_n1, busy1, done1;

  int vec = 0;
  int errs = 0;

  localparam logic [8:0] IDLE_CTL = 9'b1_1_1_1_1_0_0_0_0;

  rtc_bus_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .write(write), .addr(addr),
    .wdata(wdata), .data_in(data_in), .addr_out(addr_out), .data_out(data_out),
    .ch0_mux1(ch0_mux1), .ch1_mux1(ch1_mux1), .bus_oe(bus_oe), .cs_n(cs_n),
    .ad(ad), .wr_n(wr_n), .rd_n(rd_n), .rdata(rdata), .busy(busy), .done(done)
  );

  rtc_bus_sequencer #(.T_SU(1), .T_PW(1), .T_HD(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .write(write1), .addr(addr1),
    .wdata(wdata1), .data_in(data_in1), .addr_out(addr_out1), .data_out(data_out1),
    .ch0_mux1(ch0_mux1_1), .ch1_mux1(ch1_mux1_1), .bus_oe(bus_oe1), .cs_n(cs_n1),
    .ad(ad1), .wr_n(wr_n1), .rd_n(rd_n1), .rdata(rdata1), .busy(busy1), .done(done1)
  );

  // Control bundle order: cs_n, ad, wr_n, rd_n, ch0_mux1, ch1_mux1, bus_oe, busy, done
  logic [8:0] ctl0, ctl1;
  assign ctl0 = {cs_n, ad, wr_n, rd_n, ch0_mux1, ch1_mux1, bus_oe, busy, done};
  assign ctl1 = {cs_n1, ad1, wr_n1, rd_n1, ch0_mux1_1, ch1_mux1_1, bus_oe1, busy1, done1};

  // Expected controls in cycle n after the start cycle (n=0), from the phase timing.
  function automatic logic [8:0] exp_ctl(input int n, input bit wr,
                                         input int su, input int pw, input int hd);
    int astb, ahld, dset, dstb, dhld, fin;
    logic c_cs, c_ad, c_wr, c_rd, c_c0, c_c1, c_oe, c_bsy, c_dn;
    astb = 1 + su; ahld = astb + pw; dset = ahld + hd;
    dstb = dset + su; dhld = dstb + pw; fin = dhld + hd;
    c_cs = 1; c_ad = 1; c_wr = 1; c_rd = 1; c_c0 = 1; c_c1 = 0; c_oe = 0; c_bsy = 0; c_dn = 0;
    if (n >= 1 && n < dset) begin
      c_cs = 0; c_ad = 0; c_c0 = 0; c_oe = 1; c_bsy = 1;
      if (n >= astb && n < ahld) c_wr = 0;
    end else if (n >= dset && n < fin) begin
      c_cs = 0; c_c0 = 0; c_c1 = 1; c_oe = wr; c_bsy = 1;
      if (n >= dstb && n < dhld) begin
        if (wr) c_wr = 0;
        else    c_rd = 0;
      end
    end else if (n == fin) begin
      c_bsy = 1; c_dn = 1;
    end
    return {c_cs, c_ad, c_wr, c_rd, c_c0, c_c1, c_oe, c_bsy, c_dn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; write = 1'b1; addr = 8'hAA; wdata = 8'hBB;
    start1 = 1'b1;
    repeat (3) tick();
    vec++;
    if (ctl0 !== IDLE_CTL) begin
      errs++; $display("FAIL reset_ctl got %b exp %b", ctl0, IDLE_CTL);
    end
    vec++;
    if ({addr_out, data_out, rdata} !== 24'h000000) begin
      errs++; $display("FAIL reset_regs got %h exp 000000", {addr_out, data_out, rdata});
    end
    vec++;
    if (ctl1 !== IDLE_CTL) begin
      errs++; $display("FAIL reset_ctl_fast got %b exp %b", ctl1, IDLE_CTL);
    end
    start = 1'b0; start1 = 1'b0; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++;
      if (busy !== 1'b0) begin
        errs++; $display("FAIL reset_release_busy cyc=%0d got %b exp 0", i, busy);
      end
    end
  endtask

  task automatic test_write();
    addr = 8'h21; wdata = 8'h45; write = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; addr = 8'h00; wdata = 8'h00;
    for (int n = 1; n <= 19; n++) begin
      vec++;
      if (ctl0 !== exp_ctl(n, 1'b1, 2, 4, 2)) begin
        errs++; $display("FAIL write_ctl n=%0d got %b exp %b", n, ctl0, exp_ctl(n, 1'b1, 2, 4, 2));
      end
      if (n == 17) begin
        vec++;
        if ({addr_out, data_out, rdata} !== {8'h21, 8'h45, 8'h00}) begin
          errs++; $display("FAIL write_regs got %h exp 214500", {addr_out, data_out, rdata});
        end
      end
      tick();
    end
  endtask

  task automatic test_read();
    addr = 8'h22; write = 1'b0; start = 1'b1; data_in = 8'hFF;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 18; n++) begin
      data_in = (n >= 11 && n <= 14) ? 8'h5A : 8'hFF;
      vec++;
      if (ctl0 !== exp_ctl(n, 1'b0, 2, 4, 2)) begin
        errs++; $display("FAIL read_ctl n=%0d got %b exp %b", n, ctl0, exp_ctl(n, 1'b0, 2, 4, 2));
      end
      if (n == 17) begin
        vec++;
        if (rdata !== 8'h5A || addr_out !== 8'h22) begin
          errs++; $display("FAIL read_rdata got %h/%h exp 5a/22", rdata, addr_out);
        end
      end
      tick();
    end
  endtask

  task automatic test_busy_ignore();
    addr = 8'h31; wdata = 8'h77; write = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      start = (n == 5 || n == 17);
      addr  = start ? 8'hEE : 8'h31;
      vec++;
      if (ctl0 !== exp_ctl(n, 1'b1, 2, 4, 2)) begin
        errs++; $display("FAIL busy_ignore_ctl n=%0d got %b exp %b", n, ctl0, exp_ctl(n, 1'b1, 2, 4, 2));
      end
      tick();
    end
    start = 1'b0;
    vec++;
    if (addr_out !== 8'h31 || rdata !== 8'h5A) begin
      errs++; $display("FAIL busy_ignore_regs got %h/%h exp 31/5a", addr_out, rdata);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    addr = 8'h40; wdata = 8'h01; write = 1'b1; start = 1'b1;
    tick();
    for (int n = 1; n <= 19; n++) begin
      logic [8:0] e;
      e = (n <= 18) ? exp_ctl(n, 1'b1, 2, 4, 2) : exp_ctl(n - 18, 1'b1, 2, 4, 2);
      vec++;
      if (ctl0 !== e) begin
        errs++; $display("FAIL b2b_ctl n=%0d got %b exp %b", n, ctl0, e);
      end
      if (n == 19) start = 1'b0;
      tick();
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else tick();
    end
    vec++;
    if (!seen) begin
      errs++; $display("FAIL b2b_second_done got timeout exp done pulse");
    end
    tick();
  endtask

  task automatic test_abort();
    addr = 8'h55; wdata = 8'h66; write = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    vec++;
    if (wr_n !== 1'b0 || ch1_mux1 !== 1'b1) begin
      errs++; $display("FAIL abort_pre got wr_n=%b ch1=%b exp 0/1", wr_n, ch1_mux1);
    end
    reset = 1'b0;
    #1;
    vec++;
    if (ctl0 !== IDLE_CTL || addr_out !== 8'h00) begin
      errs++; $display("FAIL abort_async got %b/%h exp %b/00", ctl0, addr_out, IDLE_CTL);
    end
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      vec++;
      if (ctl0 !== IDLE_CTL) begin
        errs++; $display("FAIL abort_stay_idle cyc=%0d got %b exp %b", i, ctl0, IDLE_CTL);
      end
    end
  endtask

  task automatic test_fast_params();
    for (int w = 1; w >= 0; w--) begin
      addr1 = 8'h10; wdata1 = 8'h20; write1 = w[0]; data_in1 = 8'hC3; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int n = 1; n <= 9; n++) begin
        vec++;
        if (ctl1 !== exp_ctl(n, w[0], 1, 1, 1)) begin
          errs++; $display("FAIL fast_ctl w=%0d n=%0d got %b exp %b", w, n, ctl1, exp_ctl(n, w[0], 1, 1, 1));
        end
        tick();
      end
      vec++;
      if (rdata1 !== (w[0] ? 8'h00 : 8'hC3)) begin
        errs++; $display("FAIL fast_rdata w=%0d got %h exp %h", w, rdata1, w[0] ? 8'h00 : 8'hC3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_busy_ignore();
    test_back_to_back();
    test_abort();
    test_fast_params();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Transaction sequencer for the multiplexed address/data bus of the external RTC chip. It sits directly upstream of the 8-bit bus output mux and drives that mux's `ch0` (address byte), `ch1` (data byte) and phase selects `ch0_mux1`/`ch1_mux1`. It also generates the chip strobes (`cs_n`, `ad`, `wr_n`, `rd_n`) and the bus drive enable. It runs one single-byte read or write per `start` and returns read data to the controller.

## Interface
- `T_SU`, 2: setup cycles per phase, minimum 1.
- `T_PW`, 4: strobe-low cycles per phase, minimum 1.
- `T_HD`, 2: hold cycles per phase, minimum 1.
- `CNT_W`, 4: phase counter width; each of `T_SU`/`T_PW`/`T_HD` must be ≤ 2^CNT_W.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  transaction request; sampled only in IDLE.
- `write`  in  1  1 = write, 0 = read; latched with `start`.
- `addr`  in  8  register address; latched with `start`.
- `wdata`  in  8  write data; latched with `start`.
- `data_in`  in  8  bus read-back value.
- `addr_out`  out  8  latched address; drives mux `ch0`.
- `data_out`  out  8  latched write data; drives mux `ch1`.
- `ch0_mux1`  out  1  mux phase select.
- `ch1_mux1`  out  1  mux phase select.
- `bus_oe`  out  1  bus driver enable.
- `cs_n`, `ad`, `wr_n`, `rd_n`  out  1 each  RTC chip select, address/data select, write strobe, read strobe.
- `rdata`  out  8  captured read data.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Moore FSM with states IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, FIN. Every output is registered or decoded from registered state only.
- IDLE:
  - Outputs: `cs_n`=1, `ad`=1, `wr_n`=`rd_n`=1, `ch0_mux1`=1, `ch1_mux1`=0, `bus_oe`=0, `busy`=0.
  - On `start`=1: latch `addr`→`addr_out`, `wdata`→`data_out`, and `write`, then go to A_SET.
- Address phase, states A_SET → A_STB → A_HLD:
  - `cs_n`=0, `ad`=0, `ch0_mux1`=0, `ch1_mux1`=0, so the mux passes `ch0` (the address). `bus_oe`=1.
  - `wr_n`=0 only in A_STB; the address phase is always a write cycle, regardless of `write`.
- Data phase, states D_SET → D_STB → D_HLD:
  - `cs_n`=0, `ad`=1, `ch0_mux1`=0, `ch1_mux1`=1, so the mux passes `ch1` (the data). `bus_oe`=latched `write`.
  - In D_STB: `wr_n`=0 if write, else `rd_n`=0.
  - For a read, `data_in` is captured into `rdata` on the edge that leaves D_STB.
- State durations: A_SET/D_SET last `T_SU` cycles, A_STB/D_STB last `T_PW` cycles, A_HLD/D_HLD last `T_HD` cycles.
- Phase counter: loaded with duration−1 on state entry, decremented each cycle, state advances when it reaches 0.
- FIN lasts 1 cycle:
  - Outputs return to their IDLE values, except `busy`=1 and `done`=1.
  - Next state is IDLE unconditionally.
- `start` outside IDLE (including in FIN) is ignored and not queued.
- `addr_out`, `data_out` and `rdata` hold their values until the next accepted `start` (addr/data) or the next read capture (`rdata`).
- `rdata` is unchanged by write transactions.

## Timing
- Reset values (immediate on `reset`=0, independent of `clk`):
  - state IDLE, counter 0.
  - `cs_n`=`wr_n`=`rd_n`=`ad`=`ch0_mux1`=1.
  - `ch1_mux1`=`bus_oe`=`busy`=`done`=0.
  - `addr_out`=`data_out`=`rdata`=0x00.
- Reset mid-transaction aborts it: strobes and `cs_n` rise asynchronously and nothing resumes after release.
- With `start` sampled at edge k, A_SET begins at edge k+1 and FIN (`done`=1) begins at edge k+1+2·(T_SU+T_PW+T_HD). With defaults, `done` is high in cycle k+17.
- `busy` is high from edge k+1 through FIN inclusive.
- Minimum start-to-start spacing is 2·(T_SU+T_PW+T_HD)+2 cycles. FIN plus one IDLE cycle separate back-to-back transactions.
- Mux phase changes (`ch1_mux1` rising) coincide with `ad` rising at D_SET entry. Both occur while all strobes are high, so the bus value never changes under an active strobe.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `start`=1 → all outputs at reset values; after release `busy` stays 0 until the first accepted `start`.
- Write, addr 0x21, wdata 0x45, defaults:
  - `wr_n` low exactly in cycles k+3..k+6 (`ch1_mux1`=0) and k+11..k+14 (`ch1_mux1`=1).
  - `rd_n` stays high throughout.
  - `done` single pulse at k+17; `rdata` unchanged.
- Read, addr 0x22, `data_in`=0x5A during D_STB:
  - `rd_n` low 4 cycles in the data phase; `bus_oe`=0 in the data phase.
  - `rdata`=0x5A when `done`=1.
- Busy handling: pulse `start` at k+5 and at FIN → both ignored. Hold `start`=1 continuously → next A_SET begins exactly 2 cycles after FIN.
- Abort: assert `reset` during the write D_STB → `wr_n`, `cs_n` high and `ch0_mux1`=1 at once, without waiting for a clock; after release, FSM stays idle.
- Parameter override `T_SU`=`T_PW`=`T_HD`=1 → `done` at k+7, each strobe low exactly 1 cycle.
